// File: rtl/toggle_pulse_gen.sv
// Push-button conditioner: 2-FF synchronizer, debounce FSM and optional hold-to-repeat, producing
// single-cycle toggle-enable pulses on t plus a wrapping count of the pulses issued.
module toggle_pulse_gen #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned REPEAT_EN       = 1,
    parameter int unsigned REPEAT_DELAY    = 8,
    parameter int unsigned REPEAT_PERIOD   = 4,
    parameter int unsigned CNT_W           = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_in,
    output logic             t,
    output logic             pressed,
    output logic [CNT_W-1:0] pulse_cnt
);

    typedef enum logic [1:0] {StIdle, StDebPress, StHeld, StDebRelease} state_e;

    localparam logic [CNT_W-1:0] CntOne    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] DebLast   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RptFirst  = CNT_W'(REPEAT_DELAY);
    // Reloading here after each repeat makes the next hit land REPEAT_PERIOD cycles later.
    localparam logic [CNT_W-1:0] RptReload = CNT_W'(REPEAT_DELAY - REPEAT_PERIOD);

    logic             sync1_q, sync2_q;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] dcnt_q, dcnt_d;
    logic [CNT_W-1:0] rcnt_q, rcnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] rcnt_inc;
    logic             t_q, t_d;
    logic             pressed_q, pressed_d;
    logic             btn_s;

    assign btn_s = sync2_q;

    always_comb begin
        state_d   = state_q;
        dcnt_d    = dcnt_q;
        rcnt_d    = rcnt_q;
        t_d       = 1'b0;
        pressed_d = pressed_q;
        rcnt_inc  = rcnt_q + CntOne;
        unique case (state_q)
            StIdle: begin
                pressed_d = 1'b0;
                if (btn_s) begin
                    state_d = StDebPress;
                    dcnt_d  = CntOne;
                end
            end
            StDebPress: begin
                if (!btn_s) begin
                    state_d = StIdle;
                end else if (dcnt_q == DebLast) begin
                    state_d   = StHeld;
                    t_d       = 1'b1;
                    pressed_d = 1'b1;
                    rcnt_d    = '0;
                end else begin
                    dcnt_d = dcnt_q + CntOne;
                end
            end
            StHeld: begin
                if (!btn_s) begin
                    // rcnt stays frozen so a release bounce resumes the repeat schedule.
                    state_d = StDebRelease;
                    dcnt_d  = CntOne;
                end else if (rcnt_inc == RptFirst) begin
                    rcnt_d = RptReload;
                    t_d    = (REPEAT_EN != 0);
                end else begin
                    rcnt_d = rcnt_inc;
                end
            end
            StDebRelease: begin
                if (btn_s) begin
                    state_d = StHeld;
                end else if (dcnt_q == DebLast) begin
                    state_d   = StIdle;
                    pressed_d = 1'b0;
                end else begin
                    dcnt_d = dcnt_q + CntOne;
                end
            end
            default: state_d = StIdle;
        endcase
        cnt_d = t_d ? cnt_q + CntOne : cnt_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            state_q   <= StIdle;
            dcnt_q    <= '0;
            rcnt_q    <= '0;
            cnt_q     <= '0;
            t_q       <= 1'b0;
            pressed_q <= 1'b0;
        end else begin
            sync1_q   <= btn_in;
            sync2_q   <= sync1_q;
            state_q   <= state_d;
            dcnt_q    <= dcnt_d;
            rcnt_q    <= rcnt_d;
            cnt_q     <= cnt_d;
            t_q       <= t_d;
            pressed_q <= pressed_d;
        end
    end

    assign t         = t_q;
    assign pressed   = pressed_q;
    assign pulse_cnt = cnt_q;

endmodule

// File: tb/tb_toggle_pulse_gen.sv
// Directed bench for toggle_pulse_gen: hand-computed per-cycle expectations for t/pressed/pulse_cnt,
// with a second instance built with REPEAT_EN=0 sharing the same stimulus.
module tb_toggle_pulse_gen;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn_in = 1'b0;
    logic       t, pressed;
    logic [7:0] pulse_cnt;
    logic       nr_t, nr_pressed;
    logic [7:0] nr_pulse_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    toggle_pulse_gen dut (
        .clk       (clk),
        .reset     (reset),
        .btn_in    (btn_in),
        .t         (t),
        .pressed   (pressed),
        .pulse_cnt (pulse_cnt)
    );

    toggle_pulse_gen #(.REPEAT_EN(0)) dut_nr (
        .clk       (clk),
        .reset     (reset),
        .btn_in    (btn_in),
        .t         (nr_t),
        .pressed   (nr_pressed),
        .pulse_cnt (nr_pulse_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive btn_in for the next edge, then sample 1 time unit after it.
    task automatic step(input logic b, input logic exp_t, input logic exp_p, input string tag);
        btn_in = b;
        @(posedge clk);
        #1;
        chk({tag, "_t"}, {31'd0, t}, {31'd0, exp_t});
        chk({tag, "_pressed"}, {31'd0, pressed}, {31'd0, exp_p});
    endtask

    initial begin
        // Reset clears outputs before any clock edge.
        #1 reset = 1'b1;
        #1;
        chk("reset_t", {31'd0, t}, 32'd0);
        chk("reset_pressed", {31'd0, pressed}, 32'd0);
        chk("reset_cnt", {24'd0, pulse_cnt}, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Glitch: high for 3 sampling edges only.
        for (int i = 0; i < 10; i++) step(i < 3, 1'b0, 1'b0, "glitch");
        chk("glitch_cnt", {24'd0, pulse_cnt}, 32'd0);

        // Clean press: pulse after edge k+5; pressed drops at k+11.
        for (int i = 0; i < 14; i++) step(i <= 5, i == 5, (i >= 5) && (i <= 10), "press");
        chk("press_cnt", {24'd0, pulse_cnt}, 32'd1);
        chk("press_nr_cnt", {24'd0, nr_pulse_cnt}, 32'd1);

        // Auto-repeat: E = k+5, pulses at E, E+8, E+12, E+16.
        for (int i = 0; i < 31; i++) begin
            step(i <= 21, (i == 5) || (i == 13) || (i == 17) || (i == 21),
                 (i >= 5) && (i <= 26), "repeat");
            chk("repeat_nr_t", {31'd0, nr_t}, {31'd0, (i == 5)});
        end
        chk("repeat_cnt", {24'd0, pulse_cnt}, 32'd5);
        chk("repeat_nr_cnt", {24'd0, nr_pulse_cnt}, 32'd2);

        // Release bounce: btn low at edges k+7,k+8; 3 frozen cycles push the repeat to k+16.
        for (int i = 0; i < 26; i++) begin
            step(((i <= 6) || ((i >= 9) && (i <= 17))), (i == 5) || (i == 16),
                 (i >= 5) && (i <= 22), "bounce");
        end
        chk("bounce_cnt", {24'd0, pulse_cnt}, 32'd7);
        chk("bounce_nr_cnt", {24'd0, nr_pulse_cnt}, 32'd3);

        // Reset while in DEB_PRESS with dcnt=3 (after edge k+4).
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, "middeb");
        reset = 1'b1;
        #1;
        chk("middeb_rst_cnt", {24'd0, pulse_cnt}, 32'd0);
        chk("middeb_rst_t", {31'd0, t}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 14; i++) step(i <= 5, i == 5, (i >= 5) && (i <= 10), "postrst");
        chk("postrst_cnt", {24'd0, pulse_cnt}, 32'd1);

        // Counter wrap over 256 presses from reset.
        reset = 1'b1;
        #1;
        chk("wrap_rst_cnt", {24'd0, pulse_cnt}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        for (int p = 0; p < 256; p++) begin
            for (int i = 0; i < 14; i++) begin
                btn_in = (i < 6);
                @(posedge clk);
            end
            #1;
            if (p == 254) chk("wrap_255", {24'd0, pulse_cnt}, 32'd255);
        end
        chk("wrap_0", {24'd0, pulse_cnt}, 32'd0);
        chk("wrap_nr_0", {24'd0, nr_pulse_cnt}, 32'd0);
        chk("wrap_pressed", {31'd0, pressed}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/toggle_pulse_gen.md
Name: toggle_pulse_gen

Overview:
Upstream conditioning stage for the toggle flip-flop. It converts a raw, bouncy, asynchronous push-button level into clean single-cycle toggle-enable pulses on t, which drive the t input of the T flip-flop stage. It has:
- a 2-FF synchronizer,
- a debounce FSM,
- optional hold-to-repeat auto-pulsing,
- a wrapping pulse counter for observability.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable synchronized cycles required to accept a press or a release (>=2).
REPEAT_EN, 1, 1 enables auto-repeat pulses while held; 0 means one pulse per press.
REPEAT_DELAY, 8, cycles from press acceptance to the first repeat pulse (>=2).
REPEAT_PERIOD, 4, cycles between subsequent repeat pulses (>=2).
CNT_W, 8, width of pulse_cnt and of the internal timers.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high; clears all state immediately.
btn_in  input  1  raw asynchronous button level, 1 = pressed.
t  output  1  registered one-cycle toggle-enable pulse to the T flip-flop stage.
pressed  output  1  registered debounced button level.
pulse_cnt  output  CNT_W  number of t pulses issued, modulo 2^CNT_W.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high.
- Reset values:
  - t=0, pressed=0, pulse_cnt=0.
  - Synchronizer flops = 0.
  - FSM = IDLE; debounce counter and repeat counter = 0.
- Synchronizer:
  - btn_s = btn_in through two flops.
  - The FSM uses only btn_s.
  - btn_in is never used combinationally.
- FSM states: IDLE, DEB_PRESS, HELD, DEB_RELEASE.
- IDLE:
  - pressed=0.
  - btn_s=1 -> DEB_PRESS, dcnt=1.
- DEB_PRESS:
  - btn_s=0 -> IDLE. The glitch is rejected and no pulse is issued.
  - btn_s=1 and dcnt==DEBOUNCE_CYCLES-1 -> HELD. On this edge: t<=1, pressed<=1, rcnt<=0.
  - Otherwise dcnt++.
- HELD:
  - btn_s=0 -> DEB_RELEASE, dcnt=1. rcnt is frozen (not cleared).
  - Otherwise rcnt++.
  - If REPEAT_EN=1, t<=1 on the edge where the incremented rcnt equals REPEAT_DELAY.
  - Thereafter, t<=1 each time it equals REPEAT_DELAY + n*REPEAT_PERIOD, for n>=1.
  - Implement this as a reload-to-REPEAT_DELAY-REPEAT_PERIOD on each repeat pulse, so the counter never overflows.
- DEB_RELEASE:
  - No repeat pulses are issued.
  - btn_s=1 -> HELD, with rcnt resumed from its frozen value. This is a bounce on release, not a new press, so no t is issued on re-entry.
  - btn_s=0 and dcnt==DEBOUNCE_CYCLES-1 -> IDLE, pressed<=0.
  - Otherwise dcnt++.
- t rules:
  - t is high for exactly one cycle per pulse.
  - t is 0 in every cycle not listed above.
  - Two pulses are never closer than 2 cycles, since REPEAT_PERIOD>=2.
- Latency: btn_in is first sampled high at edge k and held stable. Then btn_s=1 after edge k+1, the FSM enters DEB_PRESS at edge k+2, and t=1 and pressed=1 after edge k+1+DEBOUNCE_CYCLES.
- pulse_cnt:
  - Increments on the same edge that sets t<=1.
  - Wraps from 2^CNT_W-1 to 0 with no flag.
- Reset mid-operation: asserting reset in any state clears t, pressed and pulse_cnt in the same cycle without waiting for a clock edge. After deassertion, the FSM restarts from IDLE and requires a full fresh debounce.
- btn_in changes are metastability-tolerant through the synchronizer only. There are no other asynchronous paths.

Test Plan (defaults DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=4, CNT_W=8):
1. Reset: assert reset for 2 cycles between edges -> t=0, pressed=0, pulse_cnt=0 immediately, before any clk edge.
2. Glitch reject: btn_in high for exactly 3 sampling edges, then low -> t never 1, pressed stays 0, pulse_cnt=0.
3. Clean press: btn_in high from edge k and held for 6 edges, then released -> t=1 for exactly one cycle after edge k+5, pressed=1, pulse_cnt=1. pressed returns to 0 four edges after btn_s falls.
4. Auto-repeat: btn_s high continuously for 18 edges after acceptance edge E -> t pulses after E, E+8, E+12 and E+16, pulse_cnt=4. With REPEAT_EN=0, only the pulse at E occurs and pulse_cnt=1.
5. Release bounce: while HELD, drop btn_in for 2 cycles, then high again -> pressed stays 1, no extra t pulse, and repeat timing resumes offset by the frozen cycles.
6. Reset mid-debounce and wrap:
   - Assert reset while in DEB_PRESS with dcnt=3 -> no pulse; after release a full 4-cycle debounce is required.
   - Separately, issue 256 presses -> pulse_cnt wraps to 0.
   - Optionally tie t to the T flip-flop stage and check that q toggles once per pulse.
